// File: rtl/hamming_encoder_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : hamming_encoder_tx_if
// Description : Message handshake and serial-output bundle of hamming_encoder_tx.
// Revision    : 1.0
// ============================================================================
interface hamming_encoder_tx_if;
    logic [3:0] msg;
    logic       msg_valid;
    logic       msg_ready;
    logic       flip_en;
    logic [2:0] flip_pos;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] codeword;

    modport master (
        output msg, msg_valid, flip_en, flip_pos,
        input  msg_ready, tx, busy, done, codeword
    );

    modport slave (
        input  msg, msg_valid, flip_en, flip_pos,
        output msg_ready, tx, busy, done, codeword
    );
endinterface
`default_nettype wire

// File: rtl/hamming_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module      : hamming_encoder_tx
// Description : Hamming(8,4) SECDED encoder with UART-style serialiser (MSB first).
// Revision    : 1.0
// ============================================================================
module hamming_encoder_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  wire logic            clock,
    input  wire logic            nreset,
    hamming_encoder_tx_if.slave  bus
);

    localparam int c_baud_w = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_baud_w-1:0]   r_baud_cnt;
    logic [2:0]            r_bit_cnt;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_msg_ready;
    logic [7:0]            r_codeword;

    logic                  w_accept;
    logic                  w_baud_end;
    logic [7:0]            w_flip_mask;
    logic [2:0]            w_next_bit_idx;

    // c[7:1] = {p1,p2,d3,p4,d2,d1,d0}; c[0] makes total weight even.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        c[7] = d[3] ^ d[2] ^ d[0];
        c[6] = d[3] ^ d[1] ^ d[0];
        c[5] = d[3];
        c[4] = d[2] ^ d[1] ^ d[0];
        c[3] = d[2];
        c[2] = d[1];
        c[1] = d[0];
        c[0] = ^c[7:1];
        return c;
    endfunction

    // r_msg_ready is only ever set while in IDLE, so it alone gates acceptance.
    assign w_accept       = r_msg_ready & bus.msg_valid;
    assign w_baud_end     = (r_baud_cnt == c_baud_last);
    assign w_flip_mask    = bus.flip_en ? (8'b1 << bus.flip_pos) : 8'h00;
    assign w_next_bit_idx = 3'd6 - r_bit_cnt;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_msg_ready <= 1'b0;
            r_codeword  <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_codeword  <= encode(bus.msg) ^ w_flip_mask;
                        r_state     <= ST_START;
                        r_tx        <= 1'b0;
                        r_busy      <= 1'b1;
                        r_msg_ready <= 1'b0;
                        r_baud_cnt  <= '0;
                    end else begin
                        r_msg_ready <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_DATA;
                        r_tx       <= r_codeword[7];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_STOP;
                            r_tx      <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_codeword[w_next_bit_idx];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_end) begin
                        r_baud_cnt  <= '0;
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_msg_ready <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_baud_cnt  <= '0;
                    r_bit_cnt   <= '0;
                    r_tx        <= 1'b1;
                    r_busy      <= 1'b0;
                    r_msg_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.msg_ready = r_msg_ready;
    assign bus.tx        = r_tx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.codeword  = r_codeword;

endmodule
`default_nettype wire

// File: doc/hamming_encoder_tx.md
HAMMING_ENCODER_TX -- requirements
Module: hamming_encoder_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 1..255.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 nreset  input  1  reset is synchronous and active-low, sampled on the rising edge of clock.
REQ-004 msg  input  4  message nibble {d3,d2,d1,d0}; sampled only on acceptance.
REQ-005 msg_valid  input  1  msg is valid this cycle.
REQ-006 msg_ready  output  1  block can accept msg this cycle.
REQ-007 flip_en  input  1  corrupt one codeword bit of this frame (decoder test aid); sampled on acceptance.
REQ-008 flip_pos  input  3  index (0..7) of the codeword bit inverted when flip_en=1; sampled on acceptance.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse after the stop bit completes.
REQ-012 codeword  output  8  registered codeword of the current or last frame, after any flip.

Function
REQ-013 Encoding, c[7:0]: c7=p1=d3^d2^d0; c6=p2=d3^d1^d0; c5=d3; c4=p4=d2^d1^d0; c3=d2; c2=d1; c1=d0; c0=^c[7:1] (even overall parity).
REQ-014 Flip: if flip_en=1 at acceptance, codeword[flip_pos] is inverted after encoding; the parity bit is not recomputed.
REQ-015 Acceptance occurs on a rising edge where msg_valid=1 and msg_ready=1; codeword is registered on that edge.
REQ-016 msg_ready = 1 only in IDLE; msg_ready is a registered/state-decoded output, with no combinational path from msg_valid.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 FSM transitions: IDLE->START on acceptance; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8*CLKS_PER_BIT cycles; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-019 tx per state: 1 in IDLE; 0 in START; in DATA, codeword bits MSB first (c7..c0), each held CLKS_PER_BIT cycles; 1 in STOP.
REQ-020 tx is a registered output; the first START cycle is the cycle immediately after acceptance.
REQ-021 Frame length is 10*CLKS_PER_BIT cycles.
REQ-022 busy = 1 in START, DATA and STOP; busy = 0 in IDLE.
REQ-023 done = 1 for exactly the first IDLE cycle following STOP; done = 0 otherwise.
REQ-024 Minimum acceptance spacing: 10*CLKS_PER_BIT+1 cycles. A message may be accepted in the same cycle done=1.
REQ-025 While busy, msg_valid, msg, flip_en and flip_pos are ignored; the held codeword shall not change.
REQ-026 The bit counter (3 bit) and the baud counter (width $clog2(CLKS_PER_BIT+1)) shall not wrap except at their defined terminal counts.
REQ-027 CLKS_PER_BIT=1: one cycle per bit with identical framing.

Reset
REQ-028 While nreset=0 at a rising edge, the following shall hold after that edge: state=IDLE, tx=1, busy=0, done=0, msg_ready=0, codeword=8'h00, counters=0.
REQ-029 msg_ready = 1 from the first edge on which nreset=1 is sampled.
REQ-030 Reset mid-frame aborts the frame: tx=1 on the next edge, no done pulse, and the partial frame is not resumed.

Verification
REQ-031 msg=4'b1011, CLKS_PER_BIT=4, no flip -> codeword=8'h66; tx sequence 0,0,1,1,0,0,1,1,0,1, each bit held 4 cycles; done pulses once, 40 cycles after the first START cycle.
REQ-032 Exhaustive sweep of msg 0..15 -> codeword matches REQ-013 for every value (e.g. 0->8'h00, 15->8'hFF), and every codeword has even weight.
REQ-033 msg=4'hF, flip_en=1, flip_pos=3 -> codeword=8'hF7; serial stream carries 8'hF7.
REQ-034 msg_valid held high continuously -> acceptances exactly 41 cycles apart (CLKS_PER_BIT=4); msg changes while busy do not alter tx.
REQ-035 nreset=0 pulsed during DATA bit 4 -> tx=1 and busy=0 on the next edge; no done; msg_ready=1 after nreset is released.
REQ-036 CLKS_PER_BIT=1, msg=4'b0001 -> codeword=8'hD2; frame 0,1,1,0,1,0,0,1,0,1 in 10 consecutive cycles.
